// File: rtl/deteccion_tecla.sv
// PS/2 key detector: filtered PS/2 receiver, make/break tracking, 4-digit 7-segment driver.
// Optional build macro PARITY_CHECK_EN enables odd-parity checking of received frames.
module deteccion_tecla #(
    parameter int FILTER_LEN     = 8,
    parameter int REFRESH_BITS   = 18,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2d,
    input  logic       ps2c,
    output logic [3:0] anodo,
    output logic [7:0] catodo
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StData, StDone} state_t;

    logic [1:0]            ps2c_sync, ps2d_sync;
    logic [FILTER_LEN-1:0] filter_q;
    logic                  fclk_q, fclk_d;
    logic                  fall_edge;

    state_t                state_q, state_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [9:0]            shift_q, shift_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  rx_done;
    logic                  frame_ok;
    logic [7:0]            rx_byte;

    logic [7:0]            code_q;
    logic                  valid_q;
    logic                  break_q;

    logic [REFRESH_BITS-1:0] refresh_q;
    logic [1:0]              sel;

    // Idle PS/2 lines are high, so synchronisers and filter reset to 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps2c_sync <= 2'b11;
            ps2d_sync <= 2'b11;
            filter_q  <= '1;
            fclk_q    <= 1'b1;
        end else begin
            ps2c_sync <= {ps2c_sync[0], ps2c};
            ps2d_sync <= {ps2d_sync[0], ps2d};
            filter_q  <= {ps2c_sync[1], filter_q[FILTER_LEN-1:1]};
            fclk_q    <= fclk_d;
        end
    end

    always_comb begin
        fclk_d = fclk_q;
        if (&filter_q) begin
            fclk_d = 1'b1;
        end else if (~|filter_q) begin
            fclk_d = 1'b0;
        end
    end

    assign fall_edge = fclk_q & ~fclk_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tmo_q     <= tmo_d;
        end
    end

    assign rx_byte = shift_q[7:0];

`ifdef PARITY_CHECK_EN
    assign frame_ok = shift_q[9] & (^shift_q[8:0]);
`else
    logic unused_parity;
    assign unused_parity = shift_q[8];
    assign frame_ok      = shift_q[9];
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tmo_d     = '0;
        rx_done   = 1'b0;
        case (state_q)
            StIdle: begin
                if (fall_edge && !ps2d_sync[1]) begin
                    bit_cnt_d = 4'd9;
                    state_d   = StData;
                end
            end
            StData: begin
                if (fall_edge) begin
                    shift_d = {ps2d_sync[1], shift_q[9:1]};
                    if (bit_cnt_q == 4'd0) begin
                        state_d = StDone;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 4'd1;
                    end
                end else if (tmo_q == TIMEOUT_MAX) begin
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StDone: begin
                rx_done = frame_ok;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // A break code only clears the display when it names the key being shown.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code_q  <= 8'h00;
            valid_q <= 1'b0;
            break_q <= 1'b0;
        end else if (rx_done) begin
            if (rx_byte == 8'hE0) begin
                break_q <= break_q;
            end else if (rx_byte == 8'hF0) begin
                break_q <= 1'b1;
            end else if (break_q) begin
                break_q <= 1'b0;
                if (rx_byte == code_q) begin
                    valid_q <= 1'b0;
                end
            end else begin
                code_q  <= rx_byte;
                valid_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_q <= '0;
        end else begin
            refresh_q <= refresh_q + 1'b1;
        end
    end

    assign sel = refresh_q[REFRESH_BITS-1 -: 2];

    function automatic logic [7:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 8'hC0;
            4'h1: hex7 = 8'hF9;
            4'h2: hex7 = 8'hA4;
            4'h3: hex7 = 8'hB0;
            4'h4: hex7 = 8'h99;
            4'h5: hex7 = 8'h92;
            4'h6: hex7 = 8'h82;
            4'h7: hex7 = 8'hF8;
            4'h8: hex7 = 8'h80;
            4'h9: hex7 = 8'h90;
            4'hA: hex7 = 8'h88;
            4'hB: hex7 = 8'h83;
            4'hC: hex7 = 8'hC6;
            4'hD: hex7 = 8'hA1;
            4'hE: hex7 = 8'h86;
            default: hex7 = 8'h8E;
        endcase
    endfunction

    always_comb begin
        anodo  = 4'b1110;
        catodo = 8'hFF;
        case (sel)
            2'd0: begin
                anodo = 4'b1110;
                if (valid_q) catodo = hex7(code_q[3:0]);
            end
            2'd1: begin
                anodo = 4'b1101;
                if (valid_q) catodo = hex7(code_q[7:4]);
            end
            2'd2: anodo = 4'b1011;
            default: anodo = 4'b0111;
        endcase
    end

endmodule

// File: tb/tb_deteccion_tecla.sv
// Self-checking bench for deteccion_tecla: table of PS/2 frames with expected digits,
// plus hand sequences for reset, glitch, timeout and mid-frame reset.
module tb_deteccion_tecla;

    localparam int FLEN = 8;
    localparam int RBITS = 6;
    localparam int TMO = 3000;
    localparam int HP = 80;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2d = 1'b1;
    logic       ps2c = 1'b1;
    logic [3:0] anodo;
    logic [7:0] catodo;

    int tests = 0;
    int fails = 0;

    deteccion_tecla #(
        .FILTER_LEN(FLEN),
        .REFRESH_BITS(RBITS),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ps2d(ps2d),
        .ps2c(ps2c),
        .anodo(anodo),
        .catodo(catodo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic [7:0] d0;
        logic [7:0] d1;
    } vec_t;

    vec_t vecs[11];

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                              input int nbits);
        logic [10:0] bits;
        bits = {stop, par, data, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2d = bits[i];
            repeat (HP) @(negedge clk);
            ps2c = 1'b0;
            repeat (HP) @(negedge clk);
            ps2c = 1'b1;
        end
        repeat (HP) @(negedge clk);
        ps2d = 1'b1;
        repeat (HP) @(negedge clk);
    endtask

    // Samples one full refresh period and compares the catodo seen on each digit.
    task automatic check_disp(input string name, input logic [7:0] e0, input logic [7:0] e1);
        logic [7:0] seen[4];
        for (int k = 0; k < 4; k++) seen[k] = 8'h00;
        for (int c = 0; c < (1 << RBITS); c++) begin
            @(negedge clk);
            case (anodo)
                4'b1110: seen[0] = catodo;
                4'b1101: seen[1] = catodo;
                4'b1011: seen[2] = catodo;
                4'b0111: seen[3] = catodo;
                default: ;
            endcase
        end
        check8({name, " d0"}, seen[0], e0);
        check8({name, " d1"}, seen[1], e1);
        check8({name, " d2"}, seen[2], 8'hFF);
        check8({name, " d3"}, seen[3], 8'hFF);
    endtask

    // Asserts reset off-edge, checks outputs at once, then checks the digit scan order.
    task automatic reset_and_scan(input string name);
        logic [3:0] exp_an[4];
        exp_an[0] = 4'b1110;
        exp_an[1] = 4'b1101;
        exp_an[2] = 4'b1011;
        exp_an[3] = 4'b0111;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check8({name, " anodo@reset"}, {4'h0, anodo}, 8'h0E);
        check8({name, " catodo@reset"}, catodo, 8'hFF);
        @(negedge clk);
        reset = 1'b0;
        // After k rising edges the refresh counter holds k.
        for (int k = 0; k < (1 << RBITS); k++) begin
            if (k % (1 << (RBITS - 2)) == (1 << (RBITS - 3))) begin
                check8({name, " scan anodo"}, {4'h0, anodo},
                       {4'h0, exp_an[k >> (RBITS - 2)]});
                check8({name, " scan catodo"}, catodo, 8'hFF);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        vecs[0]  = '{8'h1C, 1'b0, 1'b1, 8'hC6, 8'hF9};
        vecs[1]  = '{8'hF0, 1'b1, 1'b1, 8'hC6, 8'hF9};
        vecs[2]  = '{8'h1C, 1'b0, 1'b1, 8'hFF, 8'hFF};
        vecs[3]  = '{8'h1C, 1'b0, 1'b1, 8'hC6, 8'hF9};
        vecs[4]  = '{8'hF0, 1'b1, 1'b1, 8'hC6, 8'hF9};
        vecs[5]  = '{8'h32, 1'b0, 1'b1, 8'hC6, 8'hF9};
        vecs[6]  = '{8'hE0, 1'b0, 1'b1, 8'hC6, 8'hF9};
        vecs[7]  = '{8'h75, 1'b0, 1'b1, 8'h92, 8'hF8};
        vecs[8]  = '{8'h1C, 1'b0, 1'b0, 8'h92, 8'hF8};
`ifdef PARITY_CHECK_EN
        vecs[9]  = '{8'h1C, 1'b1, 1'b1, 8'h92, 8'hF8};
`else
        vecs[9]  = '{8'h1C, 1'b1, 1'b1, 8'hC6, 8'hF9};
`endif
        vecs[10] = '{8'h5A, 1'b1, 1'b1, 8'h88, 8'h92};

        repeat (5) @(negedge clk);
        reset_and_scan("power-up");

        for (int i = 0; i < 11; i++) begin
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stop, 11);
            check_disp($sformatf("vec%0d byte %h", i, vecs[i].data), vecs[i].d0, vecs[i].d1);
        end

        // 2-clk low glitch with data low must not be taken as a start bit.
        @(negedge clk);
        ps2d = 1'b0;
        ps2c = 1'b0;
        repeat (2) @(negedge clk);
        ps2c = 1'b1;
        repeat (50) @(negedge clk);
        ps2d = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'h3C, 1'b1, 1'b1, 11);
        check_disp("after glitch 3C", 8'hC6, 8'hB0);

        // Stall after 4 bits; receiver must time out before the next frame.
        send_frame(8'h1C, 1'b0, 1'b1, 4);
        repeat (TMO + 500) @(negedge clk);
        send_frame(8'h1C, 1'b0, 1'b1, 11);
        check_disp("after timeout 1C", 8'hC6, 8'hF9);

        // Reset in the middle of a frame, then a clean frame.
        send_frame(8'h75, 1'b0, 1'b1, 5);
        reset_and_scan("mid-frame");
        check_disp("post-reset blank", 8'hFF, 8'hFF);
        send_frame(8'h3C, 1'b1, 1'b1, 11);
        check_disp("post-reset 3C", 8'hC6, 8'hB0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
